// File: rtl/ws2812_rx.sv
// WS2812 single-LED emulator: decodes pulse-width bits, captures the first pixel of a frame, forwards the rest.
// Latency: pixel_valid 3 clk after the 24th din fall; dout = din delayed 3 clk in PASS; no backpressure (free-running stream).
module ws2812_rx #(
    parameter int t_bit_thresh = 8,
    parameter int t_min_high   = 2,
    parameter int t_frame_gap  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic       dout,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       pixel_valid,
    output logic       frame_end
);
    typedef enum logic [1:0] {WAIT_GAP, CAPTURE, PASS} state_t;

    localparam logic [9:0] GAP    = 10'(t_frame_gap);
    localparam logic [9:0] GAP_M1 = 10'(t_frame_gap - 1);
    localparam logic [8:0] THRESH = 9'(t_bit_thresh);
    localparam logic [8:0] MIN_HI = 9'(t_min_high);

    state_t      state;
    logic        s1, s2, s3;
    logic [7:0]  high_cnt;
    logic [9:0]  low_cnt;
    logic [4:0]  bit_cnt;
    // Only the first 23 bits need to be held; the 24th is taken straight from the decoder.
    logic [22:0] shift;

    logic       rise, fall, bit_ok, bit_val, gap_hit;
    logic [8:0] pulse_len;

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign pulse_len = {1'b0, high_cnt} + 9'd1;
    assign bit_ok    = fall && (pulse_len >= MIN_HI);
    assign bit_val   = (pulse_len >= THRESH);
    // True on the edge where low_cnt becomes the gap length; saturation makes it fire once per gap.
    assign gap_hit   = ~s2 && (low_cnt == GAP_M1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_GAP;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            dout        <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            pixel_valid <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;

            if (rise)
                high_cnt <= '0;
            else if (s2 && high_cnt != 8'hFF)
                high_cnt <= high_cnt + 8'd1;

            if (s2)
                low_cnt <= '0;
            else if (low_cnt != GAP)
                low_cnt <= low_cnt + 10'd1;

            pixel_valid <= 1'b0;
            frame_end   <= 1'b0;
            dout        <= 1'b0;

            case (state)
                WAIT_GAP: begin
                    if (gap_hit)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    if (bit_ok) begin
                        shift <= {shift[21:0], bit_val};
                        if (bit_cnt == 5'd23) begin
                            {red, green, blue} <= {shift, bit_val};
                            pixel_valid        <= 1'b1;
                            bit_cnt            <= '0;
                            state              <= PASS;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (gap_hit) begin
                        frame_end <= (bit_cnt != 5'd0);
                        bit_cnt   <= '0;
                    end
                end
                PASS: begin
                    dout <= s2;
                    if (gap_hit) begin
                        frame_end <= 1'b1;
                        state     <= CAPTURE;
                    end
                end
                default: state <= WAIT_GAP;
            endcase
        end
    end
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Serial receiver for the WS2812 single-wire LED protocol, at 12 MHz. It decodes the pulse-width-coded stream produced by the team's WS2812 driver and emulates one LED in the chain. The first 24-bit pixel after each frame gap is captured as 8-bit red, green and blue. Every later bit in the same frame is regenerated on `dout` for the next device. It serves both as a daisy-chain stage and as the scoreboard front end for driver verification.

## Interface
- `t_bit_thresh`, default 8: a high pulse of at least this many clk cycles decodes as 1; a shorter one decodes as 0.
- `t_min_high`, default 2: a high pulse shorter than this many cycles is a glitch and is ignored.
- `t_frame_gap`, default 300: this many consecutive low cycles marks a frame boundary.
- `clk  input  1`: 12 MHz clock. All logic is on the rising edge.
- `reset  input  1`: synchronous, active-high reset.
- `din  input  1`: serial WS2812 stream, asynchronous to clk.
- `dout  output  1`: forwarded stream for downstream pixels.
- `red  output  8`: captured red byte (stream bits 23:16).
- `green  output  8`: captured green byte (stream bits 15:8).
- `blue  output  8`: captured blue byte (stream bits 7:0).
- `pixel_valid  output  1`: one-cycle strobe; `red`, `green` and `blue` are updated in the same cycle.
- `frame_end  output  1`: one-cycle strobe when a frame gap ends an active frame.

## Operation
- **Input sync:** `din` passes through two flops (s1, s2). A third flop s3 holds the previous s2. All decoding uses s2.
  - Rising edge: s2=1 and s3=0.
  - Falling edge: s2=0 and s3=1.
- **`high_cnt` (8-bit):** cleared on a rising edge, incremented while s2=1, saturates at 255.
- **`low_cnt` (10-bit):** cleared when s2=1, incremented while s2=0, saturates at `t_frame_gap`.
- **Bit decode:** on each falling edge, the pulse length L is `high_cnt` + 1.
  - L < `t_min_high`: no bit.
  - L >= `t_bit_thresh`: bit = 1.
  - Otherwise: bit = 0.
- **Capture:** the 24-bit shift register is MSB-first, shifting left with the new bit in bit 0. A 5-bit counter counts bits 0..23.
- **States:**
  - WAIT_GAP (reset state): ignore all pulses. When `low_cnt` reaches `t_frame_gap`, go to CAPTURE silently, with no `frame_end`.
  - CAPTURE: shift in each decoded bit.
    - On the 24th bit, load {red, green, blue} from the shift register including the new bit, pulse `pixel_valid`, clear the bit counter, and go to PASS.
    - If `low_cnt` reaches `t_frame_gap` with 1..23 bits captured: discard the partial pixel, clear the bit counter, pulse `frame_end`, and stay in CAPTURE.
    - If the gap is reached with 0 bits captured: no strobe.
  - PASS: `dout` <= s2 every cycle. When `low_cnt` reaches `t_frame_gap`, pulse `frame_end` and go to CAPTURE.
- **`dout`:** registered 0 in every state except PASS. The switch from CAPTURE to PASS occurs at a falling edge, so the next forwarded high pulse is always complete.
- **Strobe rule:** `low_cnt` saturates, so `frame_end` fires at most once per gap. `pixel_valid` fires at most once per frame.
- **Reset values:**
  - `dout`, `red`, `green`, `blue`, `pixel_valid`, `frame_end` = 0.
  - s1, s2, s3 = 0; `high_cnt`, `low_cnt` and the bit counter = 0; state = WAIT_GAP.
- **Reset mid-operation:** a partial pixel is lost, with no strobe. The block must see a full gap again before capturing.

## Timing
- `din` changes before clk edge k. Then s1 changes at edge k, s2 at edge k+1, and s3 at edge k+2.
- `pixel_valid` and the new RGB values appear at edge k+2, where the 24th falling edge occurred before edge k. `pixel_valid` is high for exactly one cycle.
- `dout` in PASS equals `din` delayed by 3 edges, with pulse widths preserved cycle-exactly.
- `frame_end` is registered at the edge where `low_cnt` becomes `t_frame_gap`. That is `t_frame_gap` cycles after s2 falls, or `t_frame_gap`+2 cycles after `din` falls.
- A high pulse of 255 cycles or more saturates `high_cnt` and decodes as 1.
- A falling edge and gap saturation cannot occur in the same cycle, because a falling edge clears the low run.
- Nominal driver waveform, 16 cycles per bit:
  - Bit 1: 10 cycles high, 6 low.
  - Bit 0: 5 cycles high, 11 low.
  - Frame gap: 600 cycles low.

## Test plan
- **Capture:** reset, hold `din` low for 400 cycles, then send 24 bits of 0xA5C33C with the nominal waveform -> `red`=0xA5, `green`=0xC3, `blue`=0x3C; `pixel_valid` high for one cycle, 3 edges after the 24th falling edge; `dout`=0 throughout.
- **Forwarding:** continue straight into a second pixel 0x00FF00, then 600 low cycles -> `dout` reproduces the second pixel exactly, delayed by 3 cycles; RGB unchanged; exactly one `frame_end`, `t_frame_gap`+2 cycles after the final `din` fall; no second `pixel_valid`.
- **Partial frame:** after the gap, send 10 bits, then a 300-cycle gap, then 0x123456 -> one `frame_end`, no `pixel_valid` for the partial pixel, and the next pixel decodes to 0x12, 0x34, 0x56.
- **Glitches and thresholds:** inside a capture, send 1-cycle highs between bits, plus bits with pulse lengths of exactly 7 and 8 cycles -> glitches ignored, no bit shift; 7 decodes as 0 and 8 as 1; a 400-cycle high decodes as 1.
- **Reset mid-operation:** assert `reset` for 1 cycle after 12 bits -> all outputs 0; bits sent without a 300-cycle gap are ignored; capture resumes only after a full gap.
